// File: rtl/output_deskew_buffer.sv
// -----------------------------------------------------------------------------
// output_deskew_buffer
//
// Read-side deskew stage for the systolic array. Column j delivers its
// partial sum for a given row j cycles after column 0 does. Each column has
// its own circular FIFO. A row is presented only once every column holds its
// element for that row. Aligned rows leave through a valid/ready handshake.
//
// Optional build macro: OUTPUT_DESKEW_SKEW_CHECK_EN
//   When defined, the block checks for exactly one cycle of skew between
//   adjacent column write strobes and raises a sticky skew_err on violation.
//   When undefined, no checker state is built and skew_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   clear      in   synchronous clear of pointers, counters and flags
//   num_rows   in   rows expected for the current tile
//   wr_en      in   per-column write strobe (bit j = column j)
//   i_data     in   per-column element, lane j at [j*P_BITWIDTH +: P_BITWIDTH]
//   o_valid    out  an aligned row is available
//   o_ready    in   downstream accepts the row
//   o_data     out  aligned row, same lane packing as i_data
//   row_count  out  rows popped since reset or clear (wraps)
//   done       out  row_count == num_rows and num_rows != 0
//   overflow   out  sticky: a write was dropped on a full column
//   skew_err   out  sticky: column strobes were not one cycle apart
// -----------------------------------------------------------------------------
module output_deskew_buffer #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clear,
    input  logic [CNT_W-1:0]               num_rows,
    input  logic [SYS_COLS-1:0]            wr_en,
    input  logic [SYS_COLS*P_BITWIDTH-1:0] i_data,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [SYS_COLS*P_BITWIDTH-1:0] o_data,
    output logic [CNT_W-1:0]               row_count,
    output logic                           done,
    output logic                           overflow,
    output logic                           skew_err
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [AW:0]       DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]       CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]       CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]     PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]     PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ROW_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ROW_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Column storage (contents need no reset; occupancy gates visibility)
    logic [P_BITWIDTH-1:0] mem_q [SYS_COLS][DEPTH];

    // Per-column write pointers and occupancy counters
    logic [AW-1:0] wr_ptr_q [SYS_COLS];
    logic [AW-1:0] wr_ptr_d [SYS_COLS];
    logic [AW:0]   cnt_q    [SYS_COLS];
    logic [AW:0]   cnt_d    [SYS_COLS];

    // All columns pop together, so a single shared read pointer suffices
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] row_count_q, row_count_d;
    logic             overflow_q, overflow_d;

    logic [SYS_COLS-1:0] nempty_s;
    logic [SYS_COLS-1:0] full_s;
    logic [SYS_COLS-1:0] wr_acc_s;
    logic [SYS_COLS-1:0] wr_drop_s;
    logic                pop_s;

    // Per-column occupancy flags and write acceptance
    always_comb begin
        nempty_s  = {SYS_COLS{1'b0}};
        full_s    = {SYS_COLS{1'b0}};
        wr_acc_s  = {SYS_COLS{1'b0}};
        wr_drop_s = {SYS_COLS{1'b0}};
        for (int j = 0; j < SYS_COLS; j++) begin
            nempty_s[j]  = (cnt_q[j] != CNT_ZERO);
            full_s[j]    = (cnt_q[j] == DEPTH_CNT);
            // A full column still accepts a write when the same cycle pops it
            wr_acc_s[j]  = wr_en[j] & (~full_s[j] | pop_s);
            wr_drop_s[j] = wr_en[j] & full_s[j] & ~pop_s;
        end
    end

    // A row is ready only when every column holds its element
    assign o_valid = &nempty_s;
    assign pop_s   = o_valid & o_ready;

    // Next-state computation for pointers, counters and sticky overflow
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        row_count_d = row_count_q;
        overflow_d  = overflow_q;
        for (int j = 0; j < SYS_COLS; j++) begin
            wr_ptr_d[j] = wr_ptr_q[j];
            cnt_d[j]    = cnt_q[j];
        end
        if (clear) begin
            rd_ptr_d    = PTR_ZERO;
            row_count_d = ROW_ZERO;
            overflow_d  = 1'b0;
            for (int j = 0; j < SYS_COLS; j++) begin
                wr_ptr_d[j] = PTR_ZERO;
                cnt_d[j]    = CNT_ZERO;
            end
        end else begin
            for (int j = 0; j < SYS_COLS; j++) begin
                if (wr_acc_s[j]) begin
                    wr_ptr_d[j] = wr_ptr_q[j] + PTR_ONE;
                end else begin
                    wr_ptr_d[j] = wr_ptr_q[j];
                end
                case ({wr_acc_s[j], pop_s})
                    2'b10:   cnt_d[j] = cnt_q[j] + CNT_ONE;
                    2'b01:   cnt_d[j] = cnt_q[j] - CNT_ONE;
                    default: cnt_d[j] = cnt_q[j];
                endcase
            end
            if (pop_s) begin
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                row_count_d = row_count_q + ROW_ONE;
            end else begin
                rd_ptr_d    = rd_ptr_q;
                row_count_d = row_count_q;
            end
            if (|wr_drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= PTR_ZERO;
            row_count_q <= ROW_ZERO;
            overflow_q  <= 1'b0;
            for (int j = 0; j < SYS_COLS; j++) begin
                wr_ptr_q[j] <= PTR_ZERO;
                cnt_q[j]    <= CNT_ZERO;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            row_count_q <= row_count_d;
            overflow_q  <= overflow_d;
            for (int j = 0; j < SYS_COLS; j++) begin
                wr_ptr_q[j] <= wr_ptr_d[j];
                cnt_q[j]    <= cnt_d[j];
            end
        end
    end

    // Column storage writes
    always_ff @(posedge clk) begin
        for (int j = 0; j < SYS_COLS; j++) begin
            if (wr_acc_s[j] && !clear) begin
                mem_q[j][wr_ptr_q[j]] <= i_data[j*P_BITWIDTH +: P_BITWIDTH];
            end
        end
    end

    // First-word-fall-through read of the head row
    always_comb begin
        o_data = {(SYS_COLS*P_BITWIDTH){1'b0}};
        for (int j = 0; j < SYS_COLS; j++) begin
            o_data[j*P_BITWIDTH +: P_BITWIDTH] = mem_q[j][rd_ptr_q];
        end
    end

    assign row_count = row_count_q;
    assign overflow  = overflow_q;
    assign done      = (row_count_q == num_rows) && (num_rows != ROW_ZERO);

`ifdef OUTPUT_DESKEW_SKEW_CHECK_EN
    // wr_dly_q[j] holds wr_en[j] from the previous cycle; column j+1 must match it
    logic [SYS_COLS-2:0] wr_dly_q;
    logic                skew_err_q, skew_err_d;
    logic                skew_hit_s;

    // Skew violation detection and sticky flag update
    always_comb begin
        skew_hit_s = (wr_en[SYS_COLS-1:1] != wr_dly_q);
        if (clear) begin
            skew_err_d = 1'b0;
        end else if (skew_hit_s) begin
            skew_err_d = 1'b1;
        end else begin
            skew_err_d = skew_err_q;
        end
    end

    // Skew checker state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_dly_q   <= {(SYS_COLS-1){1'b0}};
            skew_err_q <= 1'b0;
        end else if (clear) begin
            wr_dly_q   <= {(SYS_COLS-1){1'b0}};
            skew_err_q <= 1'b0;
        end else begin
            wr_dly_q   <= wr_en[SYS_COLS-2:0];
            skew_err_q <= skew_err_d;
        end
    end

    assign skew_err = skew_err_q;
`else
    assign skew_err = 1'b0;
`endif

endmodule
